// File: rtl/cpu_divider_pkg.sv
// Shared types and constants for the iterative restoring divider.
// State encodings stay plain logic constants so legacy code can compare raw values.
package cpu_divider_pkg;
   localparam int CPU_DATA_WIDTH    = 32;
   localparam int DIVIDE_ITERATIONS = CPU_DATA_WIDTH;

   typedef logic [1:0] State;
   localparam State WAITING_STATE = 2'd0;
   localparam State LOAD_STATE    = 2'd1;
   localparam State DIVIDE_STATE  = 2'd2;
   localparam State RETURN_STATE  = 2'd3;

   typedef struct packed {
      logic                      is_signed;
      logic [CPU_DATA_WIDTH-1:0] dividend;
      logic [CPU_DATA_WIDTH-1:0] divisor;
   } DivideRequest;
endpackage

// File: rtl/cpu_divider_if.sv
// EX <-> divider handshake: request channel plus result channel.
interface cpu_divider_if import cpu_divider_pkg::*; #(
   parameter int DATA_WIDTH = CPU_DATA_WIDTH
);
   logic                  divide_valid;
   logic                  divide_ready;
   logic                  divide_signed;
   logic [DATA_WIDTH-1:0] dividend;
   logic [DATA_WIDTH-1:0] divisor;
   logic                  result_valid;
   logic                  result_ready;
   logic [DATA_WIDTH-1:0] quotient;
   logic [DATA_WIDTH-1:0] remainder;

   modport master (
      output divide_valid, divide_signed, dividend, divisor, result_ready,
      input  divide_ready, result_valid, quotient, remainder
   );

   modport slave (
      input  divide_valid, divide_signed, dividend, divisor, result_ready,
      output divide_ready, result_valid, quotient, remainder
   );
endinterface

// File: rtl/cpu_divider_step.sv
// One restoring-division step: shift in the next dividend bit, subtract the
// divisor if it fits, and report the resulting quotient bit.
module cpu_divider_step #(
   parameter int DATA_WIDTH = 32
) (
   input  logic [DATA_WIDTH-1:0] partial,
   input  logic                  next_bit,
   input  logic [DATA_WIDTH-1:0] divisor,
   output logic [DATA_WIDTH-1:0] partial_next,
   output logic                  q_bit
);
   logic [DATA_WIDTH:0] shifted;
   logic [DATA_WIDTH:0] diff;

   assign shifted = {partial, next_bit};
   assign diff    = shifted - {1'b0, divisor};
   // partial < divisor keeps shifted < 2*divisor, so the top bit of diff is a clean borrow
   assign q_bit        = ~diff[DATA_WIDTH];
   assign partial_next = q_bit ? diff[DATA_WIDTH-1:0] : shifted[DATA_WIDTH-1:0];
endmodule

// File: rtl/cpu_divider.sv
// Radix-2 restoring divider for MIPS DIV/DIVU: one quotient bit per cycle,
// sign fix-up on the way into RETURN, cancelled by the WB flush.
module cpu_divider import cpu_divider_pkg::*; #(
   parameter int DATA_WIDTH = CPU_DATA_WIDTH
) (
   input  logic          clock,
   input  logic          reset_n,
   input  logic          flush,
   cpu_divider_if.slave  bus
);
   localparam int CW = $clog2(DATA_WIDTH);

   State                  state_q, state_d;
   DivideRequest          req_q, req_d;
   logic                  q_sign_q, q_sign_d;
   logic                  r_sign_q, r_sign_d;
   logic [DATA_WIDTH-1:0] dvd_q, dvd_d;
   logic [DATA_WIDTH-1:0] dvs_q, dvs_d;
   logic [DATA_WIDTH-1:0] part_q, part_d;
   logic [DATA_WIDTH-1:0] quotient_q, quotient_d;
   logic [DATA_WIDTH-1:0] remainder_q, remainder_d;
   logic [CW-1:0]         cnt_q, cnt_d;

   logic [DATA_WIDTH-1:0] part_next;
   logic                  q_bit;
   logic [DATA_WIDTH-1:0] q_final;
   logic                  accept;

   cpu_divider_step #(.DATA_WIDTH(DATA_WIDTH)) u_step (
      .partial      (part_q),
      .next_bit     (dvd_q[DATA_WIDTH-1]),
      .divisor      (dvs_q),
      .partial_next (part_next),
      .q_bit        (q_bit)
   );

   assign bus.divide_ready = (state_q == WAITING_STATE);
   assign bus.result_valid = (state_q == RETURN_STATE);
   assign bus.quotient     = quotient_q;
   assign bus.remainder    = remainder_q;

   assign accept = bus.divide_valid & bus.divide_ready & ~flush;
   // dvd_q doubles as the quotient shift register: dividend bits leave the top, quotient bits enter the bottom
   assign q_final = {dvd_q[DATA_WIDTH-2:0], q_bit};

   always_comb begin
      state_d     = state_q;
      req_d       = req_q;
      q_sign_d    = q_sign_q;
      r_sign_d    = r_sign_q;
      dvd_d       = dvd_q;
      dvs_d       = dvs_q;
      part_d      = part_q;
      quotient_d  = quotient_q;
      remainder_d = remainder_q;
      cnt_d       = cnt_q;
      case (state_q)
         WAITING_STATE: begin
            if (accept) begin
               req_d.is_signed = bus.divide_signed;
               req_d.dividend  = bus.dividend;
               req_d.divisor   = bus.divisor;
               q_sign_d = bus.divide_signed & (bus.dividend[DATA_WIDTH-1] ^ bus.divisor[DATA_WIDTH-1]);
               r_sign_d = bus.divide_signed & bus.dividend[DATA_WIDTH-1];
               state_d  = LOAD_STATE;
            end
         end
         LOAD_STATE: begin
            part_d = '0;
            cnt_d  = '0;
            if (req_q.divisor == '0) begin
               // MIPS leaves this undefined; return all-ones / raw dividend without sign fix
               quotient_d  = '1;
               remainder_d = req_q.dividend;
               state_d     = RETURN_STATE;
            end else begin
               dvd_d   = (req_q.is_signed & req_q.dividend[DATA_WIDTH-1]) ? -req_q.dividend : req_q.dividend;
               dvs_d   = (req_q.is_signed & req_q.divisor[DATA_WIDTH-1])  ? -req_q.divisor  : req_q.divisor;
               state_d = DIVIDE_STATE;
            end
         end
         DIVIDE_STATE: begin
            part_d = part_next;
            dvd_d  = q_final;
            cnt_d  = cnt_q + 1'b1;
            if (cnt_q == CW'(DATA_WIDTH - 1)) begin
               quotient_d  = q_sign_q ? -q_final : q_final;
               remainder_d = r_sign_q ? -part_next : part_next;
               state_d     = RETURN_STATE;
            end
         end
         RETURN_STATE: begin
            if (bus.result_ready) state_d = WAITING_STATE;
         end
         default: state_d = WAITING_STATE;
      endcase
      if (flush) begin
         state_d     = WAITING_STATE;
         quotient_d  = quotient_q;
         remainder_d = remainder_q;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= WAITING_STATE;
         req_q       <= '0;
         q_sign_q    <= 1'b0;
         r_sign_q    <= 1'b0;
         dvd_q       <= '0;
         dvs_q       <= '0;
         part_q      <= '0;
         quotient_q  <= '0;
         remainder_q <= '0;
         cnt_q       <= '0;
      end else begin
         state_q     <= state_d;
         req_q       <= req_d;
         q_sign_q    <= q_sign_d;
         r_sign_q    <= r_sign_d;
         dvd_q       <= dvd_d;
         dvs_q       <= dvs_d;
         part_q      <= part_d;
         quotient_q  <= quotient_d;
         remainder_q <= remainder_d;
         cnt_q       <= cnt_d;
      end
   end
endmodule

// File: tb/tb_cpu_divider.sv
// Directed bench for cpu_divider: hand-computed quotients/remainders, latency,
// backpressure, flush and asynchronous reset.
module tb_cpu_divider;
   logic clock;
   logic reset_n;
   logic flush;
   int   checks;
   int   errors;

   cpu_divider_if #(.DATA_WIDTH(32)) div_if ();

   cpu_divider #(.DATA_WIDTH(32)) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .flush   (flush),
      .bus     (div_if.slave)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Issue at a negedge, count edges after acceptance until result_valid, then check results.
   task automatic run_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                          input int exp_lat, input logic [31:0] eq, input logic [31:0] er,
                          input string tag);
      int n;
      check({tag, "_ready"}, 32'(div_if.divide_ready), 32'd1);
      div_if.divide_valid  = 1'b1;
      div_if.divide_signed = sgn;
      div_if.dividend      = a;
      div_if.divisor       = b;
      @(posedge clock);
      @(negedge clock);
      div_if.divide_valid = 1'b0;
      n = 0;
      while (!div_if.result_valid && n < 100) begin
         @(posedge clock);
         @(negedge clock);
         n++;
      end
      check({tag, "_latency"}, 32'(n), 32'(exp_lat));
      check({tag, "_quotient"}, div_if.quotient, eq);
      check({tag, "_remainder"}, div_if.remainder, er);
   endtask

   task automatic release_result(input string tag);
      div_if.result_ready = 1'b1;
      @(posedge clock);
      @(negedge clock);
      div_if.result_ready = 1'b0;
      check({tag, "_rv_drop"}, 32'(div_if.result_valid), 32'd0);
      check({tag, "_ready_back"}, 32'(div_if.divide_ready), 32'd1);
   endtask

   initial begin
      logic seen;
      checks = 0;
      errors = 0;
      reset_n = 1'b0;
      flush   = 1'b0;
      div_if.divide_valid  = 1'b0;
      div_if.divide_signed = 1'b0;
      div_if.dividend      = '0;
      div_if.divisor       = '0;
      div_if.result_ready  = 1'b0;
      repeat (2) @(negedge clock);
      check("rst_ready", 32'(div_if.divide_ready), 32'd1);
      check("rst_rv", 32'(div_if.result_valid), 32'd0);
      check("rst_q", div_if.quotient, 32'd0);
      check("rst_r", div_if.remainder, 32'd0);
      reset_n = 1'b1;
      @(negedge clock);

      run_div(1'b0, 32'd100, 32'd7, 33, 32'd14, 32'd2, "u100_7");
      release_result("u100_7");
      run_div(1'b1, 32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFD, 32'hFFFF_FFFF, "sm7_2");
      release_result("sm7_2");
      run_div(1'b1, 32'd7, 32'hFFFF_FFFE, 33, 32'hFFFF_FFFD, 32'd1, "s7_m2");
      release_result("s7_m2");
      run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'h8000_0000, 32'd0, "s_ovf");
      release_result("s_ovf");
      run_div(1'b0, 32'hFFFF_FFFF, 32'd1, 33, 32'hFFFF_FFFF, 32'd0, "u_max_1");
      release_result("u_max_1");
      // divide by zero: LOAD goes straight to RETURN, one edge after acceptance
      run_div(1'b0, 32'h0000_1234, 32'd0, 1, 32'hFFFF_FFFF, 32'h0000_1234, "u_dz");
      release_result("u_dz");
      run_div(1'b1, 32'hFFFF_FFFB, 32'd0, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFB, "s_dz_raw");
      release_result("s_dz_raw");

      // backpressure: a pending request must not be taken while the result is held
      run_div(1'b0, 32'd1000, 32'd9, 33, 32'd111, 32'd1, "bp");
      div_if.divide_valid = 1'b1;
      div_if.dividend     = 32'd5;
      div_if.divisor      = 32'd5;
      for (int i = 0; i < 5; i++) begin
         @(posedge clock);
         @(negedge clock);
         check("bp_rv", 32'(div_if.result_valid), 32'd1);
         check("bp_q", div_if.quotient, 32'd111);
         check("bp_r", div_if.remainder, 32'd1);
         check("bp_ready", 32'(div_if.divide_ready), 32'd0);
      end
      div_if.divide_valid = 1'b0;
      release_result("bp");

      // flush during iteration 10
      div_if.divide_valid  = 1'b1;
      div_if.divide_signed = 1'b0;
      div_if.dividend      = 32'd100;
      div_if.divisor       = 32'd3;
      @(posedge clock);
      @(negedge clock);
      div_if.divide_valid = 1'b0;
      repeat (11) @(negedge clock);
      flush = 1'b1;
      @(posedge clock);
      @(negedge clock);
      flush = 1'b0;
      check("fl_ready", 32'(div_if.divide_ready), 32'd1);
      check("fl_rv", 32'(div_if.result_valid), 32'd0);
      seen = 1'b0;
      repeat (40) begin
         @(negedge clock);
         seen = seen | div_if.result_valid;
      end
      check("fl_no_result", 32'(seen), 32'd0);
      run_div(1'b0, 32'd50, 32'd5, 33, 32'd10, 32'd0, "after_fl");
      release_result("after_fl");

      // flush coincident with a request: not accepted, outputs hold
      div_if.divide_valid = 1'b1;
      div_if.dividend     = 32'd77;
      div_if.divisor      = 32'd7;
      flush = 1'b1;
      @(posedge clock);
      @(negedge clock);
      div_if.divide_valid = 1'b0;
      flush = 1'b0;
      check("flreq_ready", 32'(div_if.divide_ready), 32'd1);
      check("flreq_q_hold", div_if.quotient, 32'd10);

      // asynchronous reset mid-DIVIDE with non-zero outputs latched
      run_div(1'b0, 32'd100, 32'd7, 33, 32'd14, 32'd2, "pre_rst");
      release_result("pre_rst");
      div_if.divide_valid = 1'b1;
      div_if.dividend     = 32'd1000;
      div_if.divisor      = 32'd9;
      @(posedge clock);
      @(negedge clock);
      div_if.divide_valid = 1'b0;
      repeat (10) @(negedge clock);
      #2 reset_n = 1'b0;
      #1;
      check("arst_ready", 32'(div_if.divide_ready), 32'd1);
      check("arst_rv", 32'(div_if.result_valid), 32'd0);
      check("arst_q", div_if.quotient, 32'd0);
      check("arst_r", div_if.remainder, 32'd0);
      @(negedge clock);
      reset_n = 1'b1;
      @(negedge clock);
      run_div(1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 33, 32'd14, 32'hFFFF_FFFE, "s_m100_m7");
      release_result("s_m100_m7");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
